// File: rtl/edge_det_pkg.sv
// Shared types for the multi-channel edge detector: per-channel mode encoding,
// channel FSM states and small mode-decoding helpers.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } state_t;

  function automatic logic mode_has_rise(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic mode_has_fall(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: synchroniser chain, glitch filter, pulse FSM with
// stretch counter, and a sticky pending flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int STRETCH     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       y,
  output logic       level,
  output logic       pending
);

  localparam logic [7:0] FILT_LAST    = 8'(FILTER_LEN - 1);
  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             filt_cnt;
  logic [7:0]             str_cnt;
  state_t                 state;

  logic synced;
  logic toggle;
  logic rise_tog;
  logic fall_tog;
  logic enter_rise;
  logic enter_fall;

  assign synced     = sync_q[SYNC_STAGES-1];
  assign toggle     = (synced != level) && (filt_cnt == FILT_LAST);
  assign rise_tog   = toggle && !level;
  assign fall_tog   = toggle && level;
  assign enter_rise = rise_tog && mode_has_rise(mode);
  assign enter_fall = fall_tog && mode_has_fall(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x};
    end
  end

  // The counter only advances while the mismatch is unbroken, so any glitch
  // shorter than FILTER_LEN cycles never reaches the level flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      level    <= 1'b0;
    end else if (synced == level || toggle) begin
      filt_cnt <= '0;
      level    <= level ^ toggle;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Mode is sampled only at a level toggle, so a pulse already running is
  // unaffected by later mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOW;
      str_cnt <= '0;
      y       <= 1'b0;
    end else if (enter_rise) begin
      state   <= S_RISE;
      str_cnt <= '0;
      y       <= 1'b1;
    end else if (enter_fall) begin
      state   <= S_FALL;
      str_cnt <= '0;
      y       <= 1'b1;
    end else if (rise_tog) begin
      state   <= S_HIGH;
      str_cnt <= '0;
      y       <= 1'b0;
    end else if (fall_tog) begin
      state   <= S_LOW;
      str_cnt <= '0;
      y       <= 1'b0;
    end else begin
      case (state)
        S_RISE: begin
          if (str_cnt == STRETCH_LAST) begin
            state   <= S_HIGH;
            str_cnt <= '0;
            y       <= 1'b0;
          end else begin
            str_cnt <= str_cnt + 8'd1;
          end
        end
        S_FALL: begin
          if (str_cnt == STRETCH_LAST) begin
            state   <= S_LOW;
            str_cnt <= '0;
            y       <= 1'b0;
          end else begin
            str_cnt <= str_cnt + 8'd1;
          end
        end
        default: begin
          str_cnt <= '0;
          y       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= enter_rise || enter_fall || (pending && !clr);
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Top level: WIDTH independent edge detector channels plus a registered
// OR of all pending flags.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int STRETCH     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   x,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pending,
  output logic               any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_det_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .STRETCH    (STRETCH)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .x      (x[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr[i]),
      .y      (y[i]),
      .level  (level[i]),
      .pending(pending[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any <= 1'b0;
    end else begin
      any <= |pending;
    end
  end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop count per channel (2..4).
REQ-003 The block SHALL have parameter FILTER_LEN, default 4, meaning the consecutive stable cycles needed to accept a level change (1..255; 1 disables filtering).
REQ-004 The block SHALL have parameter STRETCH, default 2, meaning the y pulse length in cycles (1..255).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-007 The block SHALL have port x, input, WIDTH, asynchronous raw inputs.
REQ-008 The block SHALL have port mode, input, 2*WIDTH, the per-channel mode; bits [2i+1:2i] select 00 off, 01 rising, 10 falling, 11 both.
REQ-009 The block SHALL have port clr, input, WIDTH, a per-channel synchronous clear of pending.
REQ-010 The block SHALL have port y, output, WIDTH, the per-channel qualified-edge pulse.
REQ-011 The block SHALL have port level, output, WIDTH, the per-channel filtered input level.
REQ-012 The block SHALL have port pending, output, WIDTH, the per-channel sticky event flag.
REQ-013 The block SHALL have port any, output, 1, the OR-reduction of pending, registered.

Function
REQ-014 Each channel SHALL pass x[i] through SYNC_STAGES flops, then through a filter counter that counts consecutive cycles where the synced value differs from level[i].
REQ-015 The filter counter SHALL reset to 0 on any cycle where the synced value equals level[i], so glitches shorter than FILTER_LEN cycles are suppressed entirely.
REQ-016 level[i] SHALL toggle on the clock edge where the mismatch has persisted FILTER_LEN cycles; counting the first edge that samples the new x as edge 1, the toggle happens at edge SYNC_STAGES+FILTER_LEN.
REQ-017 Each channel SHALL be a Moore FSM with states S_LOW, S_RISE, S_HIGH, S_FALL; y[i] is 1 only in S_RISE and S_FALL.
REQ-018 On a level 0->1 toggle, the FSM SHALL enter S_RISE if the mode includes rising, and S_HIGH otherwise; the 1->0 toggle enters S_FALL or S_LOW the same way.
REQ-019 S_RISE and S_FALL SHALL hold for STRETCH cycles via a stretch counter, then move to S_HIGH or S_LOW respectively.
REQ-020 A qualifying opposite edge during a stretch SHALL move directly to the other pulse state and restart the stretch counter, so y stays high continuously.
REQ-021 A non-qualifying opposite edge during a stretch SHALL end the pulse immediately and enter S_LOW or S_HIGH.
REQ-022 pending[i] SHALL set on every entry into S_RISE or S_FALL, and SHALL clear on clr[i]; if set and clear coincide, set wins.
REQ-023 A mode change SHALL affect only edges whose level toggle occurs after the change; a pulse already in progress completes.
REQ-024 Mode 00 SHALL never assert y or set pending, and level SHALL still track the input.
REQ-025 any SHALL be registered, lagging pending by one cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately force y=0, level=0, pending=0, any=0, all synchroniser flops to 0, all counters to 0, and every FSM to S_LOW, including mid-pulse or mid-filter.
REQ-027 After reset is released, an input already high SHALL be reported as a rising edge after the REQ-016 latency.

Structure
REQ-028 Package edge_det_pkg SHALL hold the mode enum (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the state enum.
REQ-029 Sub-module edge_det_channel SHALL implement one channel (synchroniser, filter, FSM, stretch, pending); the top SHALL generate WIDTH instances and the any register.

Verification (SYNC_STAGES=2, FILTER_LEN=4, STRETCH=2, WIDTH=8)
REQ-030 x[0] 0->1 held, mode=01, sampled at edge 1 -> level[0]=1 and y[0]=1 from edge 6, y[0]=0 from edge 8, pending[0]=1, any=1 from edge 7.
REQ-031 3-cycle high glitch on x[1], mode=11 -> level[1], y[1] and pending[1] stay 0 throughout.
REQ-032 x[2] rises, then falls 5 cycles after its level toggle, mode=11 -> two separate 2-cycle y[2] pulses.
REQ-033 mode=10 on x[3] with a clean rise then a fall -> no pulse on the rise, one 2-cycle y[3] pulse on the fall, level follows both.
REQ-034 clr[4]=1 on the same cycle as a new qualifying edge -> pending[4] remains 1; clr alone next cycle -> pending[4]=0.
REQ-035 rst_n low during S_RISE on channel 5 -> y, level and pending are 0 immediately; with x high held, after release y[5] pulses at edge 6.
